hilo_div_sequencer: RTL and testbench

- Multi-cycle controller and datapath for DIV/DIVU that produces the HI/LO values the pipeline carries as DivHi/DivLo.
- Sits beside the execute stage: takes its operands when a divide is issued (HasDiv asserted), iterates a restoring divider, and holds HI/LO.
- Drives stall requests to the hazard unit while a result is pending, covering both MFHI/MFLO (MfOpInD) and a second divide.

---
 rtl/hilo_div_sequencer.sv | 145 ++++++++++++++
 tb/tb_hilo_div_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_sequencer.sv
// Multi-cycle DIV/DIVU unit producing HI (remainder) and LO (quotient).
// Restoring divider on magnitudes, sign fix-up, and hazard stall outputs.
module hilo_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mf_op_D,
    output logic             busy,
    output logic             stall_mf,
    output logic             stall_div,
    output logic             done,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic             accept;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                accept = start;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_mf  = mf_op_D & (busy | done);
    assign stall_div = start & busy;

    assign mag_a = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
    assign mag_b = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;

    // Partial remainder needs one extra bit: 2*rem+1 can exceed WIDTH bits.
    assign partial = {rem, quo[WIDTH-1]};
    assign trial   = partial - {1'b0, dvs};

    assign fix_quo = dz ? '1  : (sign_q ? -quo : quo);
    assign fix_rem = dz ? dvd : (sign_r ? -rem : rem);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            div_hi      <= '0;
            div_lo      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                dvd    <= dividend;
                dvs    <= mag_b;
                quo    <= mag_a;
                rem    <= '0;
                cnt    <= CW'(WIDTH);
                sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                sign_r <= is_signed & dividend[WIDTH-1];
                dz     <= (divisor == '0);
            end else if (state == RUN) begin
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= partial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt - CW'(1);
            end
            // Results land on the DONE entry edge so they align with done.
            if (state == FIX) begin
                div_lo      <= fix_quo;
                div_hi      <= fix_rem;
                div_by_zero <= dz;
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Directed + random bench for hilo_div_sequencer.
// Expected HI/LO are queued at issue and popped on done.
module tb_hilo_div_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         mf_op_D = 1'b0;
    logic         busy;
    logic         stall_mf;
    logic         stall_div;
    logic         done;
    logic [W-1:0] div_hi;
    logic [W-1:0] div_lo;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } res_t;

    res_t sb[$];
    int   passed = 0;
    int   total = 0;

    hilo_div_sequencer #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .mf_op_D     (mf_op_D),
        .busy        (busy),
        .stall_mf    (stall_mf),
        .stall_div   (stall_div),
        .done        (done),
        .div_hi      (div_hi),
        .div_lo      (div_lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic res_t model(input logic s, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        res_t         r;
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        logic [W-1:0] q;
        logic [W-1:0] m;
        if (b == '0) begin
            r.hi = a;
            r.lo = '1;
            r.dz = 1'b1;
            return r;
        end
        ma = (s && a[W-1]) ? (~a + 1) : a;
        mb = (s && b[W-1]) ? (~b + 1) : b;
        q = ma / mb;
        m = ma % mb;
        r.lo = (s && (a[W-1] != b[W-1])) ? (~q + 1) : q;
        r.hi = (s && a[W-1]) ? (~m + 1) : m;
        r.dz = 1'b0;
        return r;
    endfunction

    task automatic issue(input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        start = 1'b1;
        is_signed = s;
        dividend = a;
        divisor = b;
        sb.push_back(model(s, a, b));
    endtask

    // Called in the cycle after the start edge; counts busy cycles to done.
    task automatic wait_done(input string tag, input int exp_busy);
        int   n = 0;
        int   k = 0;
        res_t e;
        while (!done && k < 100) begin
            if (busy) n++;
            k++;
            @(negedge clock);
        end
        chk({tag, "_done"}, W'(done), W'(1));
        if (exp_busy > 0) chk({tag, "_lat"}, W'(n), W'(exp_busy));
        if (done) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, W'(0), W'(1));
            end else begin
                e = sb.pop_front();
                chk({tag, "_lo"}, div_lo, e.lo);
                chk({tag, "_hi"}, div_hi, e.hi);
                chk({tag, "_dz"}, W'(div_by_zero), W'(e.dz));
            end
        end
    endtask

    task automatic run(input string tag, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
        issue(s, a, b);
        @(negedge clock);
        start = 1'b0;
        wait_done(tag, W + 1);
        @(negedge clock);
        chk({tag, "_pulse"}, W'(done), W'(0));
    endtask

    initial begin
        int bad;
        int bad_hold;
        int k;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_hi", div_hi, W'(0));
        chk("rst_lo", div_lo, W'(0));
        chk("rst_dz", W'(div_by_zero), W'(0));
        chk("rst_stall", W'({stall_mf, stall_div}), W'(0));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run("divu_100_7", 1'b0, 32'd100, 32'd7);
        chk("divu_lo_const", div_lo, 32'd14);
        chk("divu_hi_const", div_hi, 32'd2);

        // Abort a divide with reset partway through RUN.
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd999;
        divisor = 32'd4;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_hi", div_hi, W'(0));
        chk("abort_lo", div_lo, W'(0));
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) bad++;
        end
        chk("abort_no_done", W'(bad), W'(0));
        chk("abort_hi_after", div_hi, W'(0));

        run("div_m7_2", 1'b1, -32'sd7, 32'd2);
        chk("div_m7_2_lo", div_lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi", div_hi, 32'hFFFF_FFFF);
        run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo", div_lo, 32'h8000_0000);
        chk("div_ovf_hi", div_hi, 32'd0);
        run("divu_dz", 1'b0, 32'h1234, 32'd0);
        chk("divu_dz_lo", div_lo, 32'hFFFF_FFFF);
        chk("divu_dz_hi", div_hi, 32'h1234);
        chk("divu_dz_flag", W'(div_by_zero), W'(1));
        run("div_7_m2", 1'b1, 32'd7, -32'sd2);
        run("div_m7_m2", 1'b1, -32'sd7, -32'sd2);
        run("div_dz_neg", 1'b1, -32'sd5, 32'd0);
        run("divu_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // MFHI/MFLO stall: none in IDLE, held through DONE.
        mf_op_D = 1'b1;
        #1;
        chk("mf_idle", W'(stall_mf), W'(0));
        mf_op_D = 1'b0;
        issue(1'b0, 32'd1000, 32'd3);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        mf_op_D = 1'b1;
        bad = 0;
        k = 0;
        while (!done && k < 100) begin
            #1;
            if (stall_mf !== 1'b1) bad++;
            k++;
            @(negedge clock);
        end
        chk("mf_hold", W'(bad), W'(0));
        chk("mf_done_cycle", W'(stall_mf), W'(1));
        wait_done("mf_op", 0);
        @(negedge clock);
        chk("mf_after", W'(stall_mf), W'(0));
        mf_op_D = 1'b0;

        // Second divide held while busy, accepted in the DONE cycle.
        issue(1'b0, 32'd100, 32'd7);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        start = 1'b1;
        dividend = 32'd50;
        divisor = 32'd6;
        bad = 0;
        bad_hold = 0;
        k = 0;
        while (!done && k < 100) begin
            #1;
            if (stall_div !== 1'b1) bad++;
            if (div_lo !== 32'd333) bad_hold++;
            k++;
            @(negedge clock);
        end
        chk("sdiv_hold", W'(bad), W'(0));
        chk("sdiv_prev_lo", W'(bad_hold), W'(0));
        chk("sdiv_done_stall", W'(stall_div), W'(0));
        sb.push_back(model(1'b0, 32'd50, 32'd6));
        wait_done("sdiv_first", 0);
        @(negedge clock);
        start = 1'b0;
        chk("sdiv_accepted", W'(busy), W'(1));
        chk("sdiv_retain_lo", div_lo, 32'd14);
        chk("sdiv_retain_hi", div_hi, 32'd2);
        wait_done("sdiv_second", W + 1);
        chk("sdiv_second_lo", div_lo, 32'd8);
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, b);
        end

        chk("sb_drained", W'(sb.size()), W'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
